// File: rtl/run_trace_ctrl.sv
// Run-control and trace/dump unit: streams the fetched PC each cycle, then on halt or
// timeout dumps the register file, a data-memory window and an end-of-run marker.
module run_trace_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              NREGS      = 32,
    parameter logic [XLEN-1:0] MEM_BASE   = 32'h4000,
    parameter int              MEM_WORDS  = 4,
    parameter int              TIMEOUT    = 64,
    parameter logic [31:0]     HALT_INST  = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [XLEN-1:0]            pc,
    input  logic [31:0]                inst,
    output logic [$clog2(NREGS)-1:0]   rf_raddr,
    input  logic [XLEN-1:0]            rf_rdata,
    output logic [XLEN-1:0]            mem_raddr,
    input  logic [XLEN-1:0]            mem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_kind,
    output logic [XLEN-1:0]            out_data,
    output logic                       done,
    output logic                       halt_cause,
    output logic                       overflow
);
    // state      | meaning
    // S_RUN      | tracing PCs, counting cycles, watching for halt/timeout
    // S_DUMP_REG | streaming register file entries 0..NREGS-1
    // S_DUMP_MEM | streaming MEM_WORDS data words from MEM_BASE
    // S_END      | pushing the end marker carrying the cycle count
    // S_DRAIN    | waiting for the consumer to empty the FIFO
    // S_DONE     | run complete, idle until reset
    typedef enum logic [2:0] {
        S_RUN, S_DUMP_REG, S_DUMP_MEM, S_END, S_DRAIN, S_DONE
    } state_t;

    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int IMAX = (NREGS > MEM_WORDS) ? NREGS : MEM_WORDS;
    localparam int IW   = $clog2(IMAX) + 1;
    localparam int RAW  = $clog2(NREGS);
    localparam int FW   = 2 + XLEN;

    localparam logic [1:0] K_PC  = 2'd0;
    localparam logic [1:0] K_REG = 2'd1;
    localparam logic [1:0] K_MEM = 2'd2;
    localparam logic [1:0] K_END = 2'd3;

    state_t          r_state;
    state_t          w_state_next;
    logic [FW-1:0]   r_fifo [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [IW-1:0]   r_idx;
    logic [CW-1:0]   r_cnt;
    logic            r_halt_cause;
    logic            r_overflow;

    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_can_push;
    logic [CW-1:0]   w_cnt_next;
    logic            w_push;
    logic [FW-1:0]   w_push_word;
    logic            w_idx_inc;
    logic            w_idx_clr;
    logic            w_cnt_inc;
    logic            w_drop;
    logic            w_stop;
    logic            w_cause;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = !w_empty && out_ready;
    // Dump entries may refill a slot freed by the same-cycle pop; PC trace may not.
    assign w_can_push = !w_full || w_pop;
    assign w_cnt_next = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_RUN;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        w_push_word  = '0;
        w_idx_inc    = 1'b0;
        w_idx_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_drop       = 1'b0;
        w_stop       = 1'b0;
        w_cause      = 1'b0;
        case (r_state)
            S_RUN: begin
                w_cnt_inc   = 1'b1;
                w_push      = !w_full;
                w_drop      = w_full;
                w_push_word = {K_PC, pc};
                if (inst == HALT_INST) begin
                    w_stop  = 1'b1;
                    w_cause = 1'b0;
                end else if (w_cnt_next == CW'(TIMEOUT)) begin
                    w_stop  = 1'b1;
                    w_cause = 1'b1;
                end
                if (w_stop) w_state_next = S_DUMP_REG;
            end
            S_DUMP_REG: begin
                w_push_word = {K_REG, rf_rdata};
                if (w_can_push) begin
                    w_push = 1'b1;
                    if (r_idx == IW'(NREGS - 1)) begin
                        w_idx_clr    = 1'b1;
                        w_state_next = S_DUMP_MEM;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            S_DUMP_MEM: begin
                w_push_word = {K_MEM, mem_rdata};
                if (w_can_push) begin
                    w_push = 1'b1;
                    if (r_idx == IW'(MEM_WORDS - 1)) begin
                        w_idx_clr    = 1'b1;
                        w_state_next = S_END;
                    end else begin
                        w_idx_inc = 1'b1;
                    end
                end
            end
            S_END: begin
                w_push_word = {K_END, XLEN'(r_cnt)};
                if (w_can_push) begin
                    w_push       = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_halt_cause <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_idx_clr)      r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + IW'(1);
            if (w_cnt_inc) r_cnt        <= w_cnt_next;
            if (w_stop)    r_halt_cause <= w_cause;
            if (w_drop)    r_overflow   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= w_push_word;
    end

    assign out_valid             = !w_empty;
    assign {out_kind, out_data}  = r_fifo[r_rptr];
    assign done                  = (r_state == S_DONE);
    assign halt_cause            = r_halt_cause;
    assign overflow              = r_overflow;
    assign rf_raddr  = (r_state == S_DUMP_REG) ? r_idx[RAW-1:0] : '0;
    assign mem_raddr = (r_state == S_DUMP_MEM) ? MEM_BASE + XLEN'(r_idx) : MEM_BASE;

endmodule

// File: tb/tb_run_trace_ctrl.sv
// Randomized bench for run_trace_ctrl: a transaction-level model predicts the full output
// stream, halt cause and overflow for each run and the captured stream is compared to it.
module tb_run_trace_ctrl;
    localparam int          XLEN      = 32;
    localparam int          NREGS     = 32;
    localparam int          MEM_WORDS = 4;
    localparam int          TIMEOUT   = 8;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] MBASE     = 32'h4000;
    localparam logic [31:0] HALT      = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [XLEN-1:0]   pc = '0;
    logic [31:0]       inst = '0;
    logic [4:0]        rf_raddr;
    logic [XLEN-1:0]   rf_rdata;
    logic [XLEN-1:0]   mem_raddr;
    logic [XLEN-1:0]   mem_rdata;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [1:0]        out_kind;
    logic [XLEN-1:0]   out_data;
    logic              done;
    logic              halt_cause;
    logic              overflow;

    run_trace_ctrl #(
        .XLEN(XLEN), .NREGS(NREGS), .MEM_BASE(MBASE), .MEM_WORDS(MEM_WORDS),
        .TIMEOUT(TIMEOUT), .HALT_INST(HALT), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc), .inst(inst),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_data(out_data),
        .done(done), .halt_cause(halt_cause), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [31:0] memw [MEM_WORDS];
    logic [31:0] w_off;

    assign rf_rdata = 32'(rf_raddr) * 32'd3;
    always_comb begin
        mem_rdata = 32'hDEAD_BEEF;
        w_off     = mem_raddr - MBASE;
        if (w_off < 32'(MEM_WORDS)) mem_rdata = memw[w_off[1:0]];
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] got_q [$];
    logic [33:0] exp_q [$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word;
    int          tick_no;
    int          end_tick;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: observe at the falling edge, then drive inputs for the next rising edge.
    task automatic tick(input logic rdy, input logic [31:0] p, input logic [31:0] in);
        @(negedge clk);
        tick_no++;
        if (prev_stall) chk("stall_hold", 64'({out_kind, out_data}), 64'(prev_word));
        reset     = 1'b1;
        pc        = p;
        inst      = in;
        out_ready = rdy;
        if (out_valid && rdy) begin
            got_q.push_back({out_kind, out_data});
            if (out_kind == 2'd3) end_tick = tick_no;
        end
        prev_stall = out_valid && !rdy;
        prev_word  = {out_kind, out_data};
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset      = 1'b0;
        out_ready  = 1'b0;
        prev_stall = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"},   64'(out_valid),  64'd0);
        chk({tag, "_done"},    64'(done),       64'd0);
        chk({tag, "_cause"},   64'(halt_cause), 64'd0);
        chk({tag, "_ovf"},     64'(overflow),   64'd0);
        chk({tag, "_rfaddr"},  64'(rf_raddr),   64'd0);
        chk({tag, "_memaddr"}, 64'(mem_raddr),  64'(MBASE));
    endtask

    task automatic run_test(input int halt_at, input logic rdy_run, input logic rand_dump,
                            input int abort_after);
        logic [31:0] base;
        int          k;
        int          kept;
        logic        exp_cause;
        logic        exp_ovf;
        int          done_tick;
        int          n;

        base = {8'h00, 6'($urandom), 16'h0000} + {18'h0, 12'($urandom), 2'b00};
        for (int j = 0; j < MEM_WORDS; j++) memw[j] = $urandom;
        do_reset("reset");

        k         = (halt_at <= TIMEOUT) ? halt_at : TIMEOUT;
        exp_cause = (halt_at > TIMEOUT);
        kept      = rdy_run ? k : ((k < DEPTH) ? k : DEPTH);
        exp_ovf   = (kept < k);
        got_q.delete();
        exp_q.delete();
        tick_no  = 0;
        end_tick = -1;
        for (int i = 0; i < kept; i++) exp_q.push_back({2'd0, base + 32'(4 * i)});
        for (int i = 0; i < NREGS; i++) exp_q.push_back({2'd1, 32'(3 * i)});
        for (int j = 0; j < MEM_WORDS; j++) exp_q.push_back({2'd2, memw[j]});
        exp_q.push_back({2'd3, 32'(k)});

        for (int i = 1; i <= k; i++) begin
            tick(rdy_run, base + 32'(4 * (i - 1)), (i == halt_at) ? HALT : ($urandom | 32'd1));
            if (i == 2 && rdy_run)
                chk("trace_latency", 64'({out_valid, out_kind, out_data}), 64'({1'b1, 2'd0, base}));
        end

        if (abort_after > 0) begin
            repeat (abort_after) tick(1'b0, $urandom, $urandom);
            chk("mid_dump_rfaddr", 64'(rf_raddr), 64'(DEPTH - kept));
            do_reset("abort");
            return;
        end

        done_tick = -1;
        n = 0;
        while (n < 2000) begin
            tick(rand_dump ? 1'($urandom_range(0, 1)) : 1'b1, $urandom, $urandom);
            n++;
            if (done) begin
                done_tick = tick_no;
                break;
            end
        end
        if (done_tick < 0) chk("done_timeout", 64'd0, 64'd1);

        chk("stream_len", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
        chk("halt_cause",   64'(halt_cause), 64'(exp_cause));
        chk("overflow",     64'(overflow),   64'(exp_ovf));
        chk("done",         64'(done),       64'd1);
        chk("idle_valid",   64'(out_valid),  64'd0);
        chk("done_latency", 64'(done_tick - end_tick), 64'd2);
    endtask

    initial begin
        run_test(5,   1'b1, 1'b0, 0);   // halt after 4 normal instructions
        run_test(100, 1'b1, 1'b0, 0);   // timeout
        run_test(8,   1'b1, 1'b1, 0);   // halt on the timeout cycle
        run_test(7,   1'b0, 1'b0, 0);   // backpressure during run, overflow
        run_test(6,   1'b0, 1'b1, 0);
        run_test(2,   1'b0, 1'b0, 6);   // reset in the middle of the register dump
        run_test(3,   1'b1, 1'b1, 0);
        for (int t = 0; t < 6; t++)
            run_test(int'($urandom_range(1, 12)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
